elevator_ctrl: RTL and testbench
================================

// Module: elevator_ctrl
// PURPOSE
//   Elevator car controller for a 4-floor system. Latches floor-call buttons,
//   schedules travel with a direction-preserving (SCAN) policy, times floor-
//   to-floor travel and door dwell, and drives the car-status bus consumed
//   directly by the seven-segment display multiplexer (now_floor, direction,
//   door_state, pointer). Sits between the button debouncer and the display.
// PARAMETERS
//   MOVE_CYCLES  100_000_000  clk cycles to travel one floor (2 s @ 50 MHz)
//   DOOR_CYCLES  150_000_000  clk cycles door stays open (3 s @ 50 MHz)
// PORTS
//   clk          in   1  system clock, 50 MHz
//   rst_n        in   1  asynchronous, active-low reset
//   floor_req    in   4  call buttons, bit i = floor i+1; debounced, any high cycle = press
//   now_floor    out  2  current car floor, 00=1F .. 11=4F
//   direction    out  2  00 idle, 01 moving up, 10 moving down (11 never driven)
//   door_state   out  1  1 = door open, 0 = closed
//   pointer      out  2  next-travel hint: 00 none pending, 01 up, 10 down
//   req_pending  out  4  latched outstanding requests, bit i = floor i+1
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, now_floor=00, direction=00,
//     door_state=0, pointer=00, req_pending=0000, timer=0, last_dir=UP.
//   Request latch: req_pending[i] <= 1 on any cycle floor_req[i]=1, except when
//     car is in DOOR at floor i (then the press restarts the door timer instead).
//     Clear of bit i on door-open at floor i wins over a same-cycle set.
//   FSM states IDLE, MOVE, DOOR; one transition per cycle.
//   IDLE: direction=00, door_state=0.
//     - req_pending[now_floor] -> DOOR next cycle, clear that bit.
//     - else requests above and (last_dir=UP or none below) -> MOVE up, last_dir=UP.
//     - else requests below -> MOVE down, last_dir=DOWN.
//     - else stay IDLE.
//   MOVE: direction=01/10 per last_dir; timer counts 0..MOVE_CYCLES-1.
//     - at terminal count: now_floor +/- 1, timer=0, then on that same edge:
//       new floor pending -> DOOR (bit cleared); else requests further in
//       last_dir -> stay MOVE; else -> IDLE.
//     - now_floor never wraps: guard blocks increment at 11 / decrement at 00
//       (state falls to IDLE).
//   DOOR: door_state=1, direction=00; timer counts 0..DOOR_CYCLES-1, then
//     door_state=0, -> IDLE. Press of now_floor while in DOOR resets timer to 0.
//   pointer: registered, 1-cycle latency from req_pending/now_floor/last_dir;
//     01 if pending above and (last_dir=UP or none below); 10 if pending below;
//     else 00.
//   Requests arriving during MOVE for a floor already passed stay latched and
//     are served after reversal from IDLE.
//   All outputs registered; no combinational path from floor_req to outputs.
// TESTING  (MOVE_CYCLES=10, DOOR_CYCLES=20)
//   1. Reset, pulse floor_req=1000 -> direction=01 next cycle+1, now_floor
//      01,10,11 at 10-cycle steps; at 11: direction=00, door_state=1 for 20
//      cycles, req_pending=0000, then IDLE.
//   2. Idle at 00, pulse floor_req=0001 -> door_state=1 within 2 cycles for 20
//      cycles; now_floor stays 00, direction stays 00.
//   3. Travel 00->11 requested; pulse floor_req=0010 at cycle 3 -> stops at
//      01 with door open 20 cycles, then resumes up to 11.
//   4. Idle at 10 with last_dir=UP, same-cycle floor_req=1001 -> serves 11
//      first, then reverses down to 00; pointer=01 then 10 then 00.
//   5. Door open at 10, pulse floor_req=0100 at dwell cycle 15 -> door stays
//      open until 20 cycles after the press; req_pending bit 2 stays 0.
//   6. Assert rst_n=0 mid-MOVE -> all outputs at reset values without a clk
//      edge; after release no motion until a new request.

Source files
------------

// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
// elevator_ctrl : 4-floor elevator car controller with SCAN scheduling
// Rev 1.0
// ============================================================================
module elevator_ctrl #(
    parameter int unsigned MOVE_CYCLES = 100_000_000,
    parameter int unsigned DOOR_CYCLES = 150_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] floor_req,
    output logic [1:0] now_floor,
    output logic [1:0] direction,
    output logic       door_state,
    output logic [1:0] pointer,
    output logic [3:0] req_pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic        DIR_UP    = 1'b0;
    localparam logic        DIR_DN    = 1'b1;
    localparam logic [31:0] MOVE_LAST = 32'(MOVE_CYCLES - 1);
    localparam logic [31:0] DOOR_LAST = 32'(DOOR_CYCLES - 1);

    state_t      state, state_nx;
    logic [31:0] timer, timer_nx;
    logic        last_dir, last_dir_nx;
    logic [1:0]  floor_nx;
    logic [3:0]  clr_mask;
    logic [3:0]  set_mask;
    logic        pend_above, pend_below, scan_up;

    function automatic logic [3:0] above_mask(input logic [1:0] f);
        return 4'b1110 << f;
    endfunction

    function automatic logic [3:0] below_mask(input logic [1:0] f);
        return ~(4'b1111 << f);
    endfunction

    assign pend_above = |(req_pending & above_mask(now_floor));
    assign pend_below = |(req_pending & below_mask(now_floor));
    assign scan_up    = pend_above && (last_dir == DIR_UP || !pend_below);

    // A press of the floor the door is open at only extends the dwell.
    assign set_mask = floor_req & ~((state == DOOR) ? (4'b0001 << now_floor) : 4'b0000);

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        last_dir_nx = last_dir;
        floor_nx    = now_floor;
        clr_mask    = 4'b0000;
        case (state)
            IDLE: begin
                timer_nx = 32'd0;
                if (req_pending[now_floor]) begin
                    state_nx = DOOR;
                    clr_mask[now_floor] = 1'b1;
                end else if (scan_up) begin
                    state_nx    = MOVE;
                    last_dir_nx = DIR_UP;
                end else if (pend_below) begin
                    state_nx    = MOVE;
                    last_dir_nx = DIR_DN;
                end
            end
            MOVE: begin
                if (timer == MOVE_LAST) begin
                    timer_nx = 32'd0;
                    if ((last_dir == DIR_UP && now_floor == 2'd3) ||
                        (last_dir == DIR_DN && now_floor == 2'd0)) begin
                        state_nx = IDLE;
                    end else begin
                        floor_nx = (last_dir == DIR_UP) ? now_floor + 2'd1 : now_floor - 2'd1;
                        if (req_pending[floor_nx]) begin
                            state_nx = DOOR;
                            clr_mask[floor_nx] = 1'b1;
                        end else if ((last_dir == DIR_UP && |(req_pending & above_mask(floor_nx))) ||
                                     (last_dir == DIR_DN && |(req_pending & below_mask(floor_nx)))) begin
                            state_nx = MOVE;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end else begin
                    timer_nx = timer + 32'd1;
                end
            end
            DOOR: begin
                if (floor_req[now_floor]) begin
                    timer_nx = 32'd0;
                end else if (timer == DOOR_LAST) begin
                    timer_nx = 32'd0;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer + 32'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= 32'd0;
            last_dir    <= DIR_UP;
            now_floor   <= 2'd0;
            direction   <= 2'b00;
            door_state  <= 1'b0;
            pointer     <= 2'b00;
            req_pending <= 4'b0000;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            last_dir    <= last_dir_nx;
            now_floor   <= floor_nx;
            req_pending <= (req_pending | set_mask) & ~clr_mask;
            // Status outputs follow the next state so they line up with it.
            direction   <= (state_nx == MOVE) ? ((last_dir_nx == DIR_DN) ? 2'b10 : 2'b01) : 2'b00;
            door_state  <= (state_nx == DOOR);
            pointer     <= scan_up ? 2'b01 : (pend_below ? 2'b10 : 2'b00);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
`default_nettype none
// ============================================================================
// tb_elevator_ctrl : directed self-checking bench for elevator_ctrl
// Rev 1.0
// ============================================================================
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] floor_req = 4'b0000;
    logic [1:0] now_floor, direction, pointer;
    logic       door_state;
    logic [3:0] req_pending;

    int checks = 0;
    int errors = 0;

    elevator_ctrl #(.MOVE_CYCLES(10), .DOOR_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n), .floor_req(floor_req),
        .now_floor(now_floor), .direction(direction), .door_state(door_state),
        .pointer(pointer), .req_pending(req_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        int          wait_n;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    // Packed status: {now_floor, direction, door_state, pointer, req_pending}
    function automatic logic [10:0] st(input logic [1:0] f, input logic [1:0] d,
                                       input logic dr, input logic [1:0] p,
                                       input logic [3:0] r);
        return {f, d, dr, p, r};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {now_floor, direction, door_state, pointer, req_pending};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got floor=%b dir=%b door=%b ptr=%b pend=%b, expected floor=%b dir=%b door=%b ptr=%b pend=%b",
                     name, act[10:9], act[8:7], act[6], act[5:4], act[3:0],
                     exp[10:9], exp[8:7], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    task automatic do_reset();
        floor_req = 4'b0000;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic pulse(input logic [3:0] req);
        floor_req = req;
        step(1);
        floor_req = 4'b0000;
    endtask

    initial begin
        // Scenario 1: call to 4F from 1F
        vecs[0]  = '{1'b0, 4'b1000,  1, st(2'd0, 2'b00, 1'b0, 2'b00, 4'b1000), "s1_latch"};
        vecs[1]  = '{1'b0, 4'b0000,  1, st(2'd0, 2'b01, 1'b0, 2'b01, 4'b1000), "s1_start"};
        vecs[2]  = '{1'b0, 4'b0000,  9, st(2'd0, 2'b01, 1'b0, 2'b01, 4'b1000), "s1_before_1f"};
        vecs[3]  = '{1'b0, 4'b0000,  1, st(2'd1, 2'b01, 1'b0, 2'b01, 4'b1000), "s1_at_2f"};
        vecs[4]  = '{1'b0, 4'b0000, 10, st(2'd2, 2'b01, 1'b0, 2'b01, 4'b1000), "s1_at_3f"};
        vecs[5]  = '{1'b0, 4'b0000, 10, st(2'd3, 2'b00, 1'b1, 2'b01, 4'b0000), "s1_arrive_4f"};
        vecs[6]  = '{1'b0, 4'b0000,  1, st(2'd3, 2'b00, 1'b1, 2'b00, 4'b0000), "s1_ptr_clear"};
        vecs[7]  = '{1'b0, 4'b0000, 18, st(2'd3, 2'b00, 1'b1, 2'b00, 4'b0000), "s1_door_last"};
        vecs[8]  = '{1'b0, 4'b0000,  1, st(2'd3, 2'b00, 1'b0, 2'b00, 4'b0000), "s1_door_close"};
        vecs[9]  = '{1'b0, 4'b0000,  5, st(2'd3, 2'b00, 1'b0, 2'b00, 4'b0000), "s1_idle"};
        // Scenario 2: call at current floor opens door in place
        vecs[10] = '{1'b1, 4'b0001,  1, st(2'd0, 2'b00, 1'b0, 2'b00, 4'b0001), "s2_latch"};
        vecs[11] = '{1'b0, 4'b0000,  1, st(2'd0, 2'b00, 1'b1, 2'b00, 4'b0000), "s2_open"};
        vecs[12] = '{1'b0, 4'b0000, 19, st(2'd0, 2'b00, 1'b1, 2'b00, 4'b0000), "s2_door_last"};
        vecs[13] = '{1'b0, 4'b0000,  1, st(2'd0, 2'b00, 1'b0, 2'b00, 4'b0000), "s2_close"};

        step(1);
        check("reset_held", st(2'd0, 2'b00, 1'b0, 2'b00, 4'b0000));
        rst_n = 1'b1;
        step(1);
        check("reset_release", st(2'd0, 2'b00, 1'b0, 2'b00, 4'b0000));

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) do_reset();
            pulse(vecs[i].req);
            if (vecs[i].wait_n > 1) step(vecs[i].wait_n - 1);
            check(vecs[i].name, vecs[i].exp);
        end

        // Scenario 3: intermediate call picked up on the way
        do_reset();
        pulse(4'b1000);                       // k+1
        step(3);                              // k+4
        pulse(4'b0010);                       // k+5
        check("s3_latched_2f", st(2'd0, 2'b01, 1'b0, 2'b01, 4'b1010));
        step(7);                              // k+12
        check("s3_stop_2f", st(2'd1, 2'b00, 1'b1, 2'b01, 4'b1000));
        step(20);                             // k+32
        check("s3_close_2f", st(2'd1, 2'b00, 1'b0, 2'b01, 4'b1000));
        step(1);                              // k+33
        check("s3_resume", st(2'd1, 2'b01, 1'b0, 2'b01, 4'b1000));
        step(20);                             // k+53
        check("s3_arrive_4f", st(2'd3, 2'b00, 1'b1, 2'b01, 4'b0000));

        // Scenario 4: SCAN keeps going up before reversing
        do_reset();
        pulse(4'b0100);                       // k+1
        step(41);                             // k+42, door at 3F closes
        check("s4_idle_3f", st(2'd2, 2'b00, 1'b0, 2'b00, 4'b0000));
        pulse(4'b1001);                       // k+43
        step(1);                              // k+44
        check("s4_go_up", st(2'd2, 2'b01, 1'b0, 2'b01, 4'b1001));
        step(11);                             // k+55
        check("s4_at_4f", st(2'd3, 2'b00, 1'b1, 2'b10, 4'b0001));
        step(20);                             // k+75
        check("s4_go_down", st(2'd3, 2'b10, 1'b0, 2'b10, 4'b0001));
        step(31);                             // k+106
        check("s4_at_1f", st(2'd0, 2'b00, 1'b1, 2'b00, 4'b0000));

        // Scenario 5: re-press at open door extends dwell
        do_reset();
        pulse(4'b0100);                       // k+1
        step(36);                             // k+37
        pulse(4'b0100);                       // k+38, timer was 15
        check("s5_press", st(2'd2, 2'b00, 1'b1, 2'b00, 4'b0000));
        step(19);                             // k+57
        check("s5_extended", st(2'd2, 2'b00, 1'b1, 2'b00, 4'b0000));
        step(1);                              // k+58
        check("s5_close", st(2'd2, 2'b00, 1'b0, 2'b00, 4'b0000));

        // Scenario 6: asynchronous reset in the middle of travel
        do_reset();
        pulse(4'b1000);                       // k+1
        step(14);                             // k+15
        check("s6_moving", st(2'd1, 2'b01, 1'b0, 2'b01, 4'b1000));
        rst_n = 1'b0;
        #2;
        check("s6_async_reset", st(2'd0, 2'b00, 1'b0, 2'b00, 4'b0000));
        rst_n = 1'b1;
        step(15);
        check("s6_no_motion", st(2'd0, 2'b00, 1'b0, 2'b00, 4'b0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
